// File: rtl/vga_display_ctrl_if.sv
// Raster coordinates and registered pixel outputs from the display controller,
// plus the fill and game-state flags returned by the layer generators.
interface vga_display_ctrl_if;
  logic        pacmanFill;
  logic        ghostFill;
  logic        dotFill;
  logic        wallFill;
  logic        win;
  logic        lose;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        pixEn;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic [11:0] rgb;
  logic        frameTick;

  modport master (
    input  pacmanFill, ghostFill, dotFill, wallFill, win, lose,
    output hCount, vCount, pixEn, hSync, vSync, bright, rgb, frameTick
  );

  modport slave (
    output pacmanFill, ghostFill, dotFill, wallFill, win, lose,
    input  hCount, vCount, pixEn, hSync, vSync, bright, rgb, frameTick
  );
endinterface

// File: rtl/vga_display_ctrl.sv
// 640x480@60 raster timing generator and layer-priority pixel compositor.
// Define VGA_PLAYFIELD_BORDER_EN to draw a 2-pixel frame around the playfield.
module vga_display_ctrl #(
  parameter int          CLK_DIV     = 4,
  parameter int          H_TOTAL     = 800,
  parameter int          H_SYNC      = 96,
  parameter int          H_VIS_START = 144,
  parameter int          H_VIS_END   = 783,
  parameter int          V_TOTAL     = 525,
  parameter int          V_SYNC      = 2,
  parameter int          V_VIS_START = 35,
  parameter int          V_VIS_END   = 514,
  parameter logic [11:0] PAC_RGB     = 12'hFF0,
  parameter logic [11:0] GHOST_RGB   = 12'hF0F,
  parameter logic [11:0] DOT_RGB     = 12'hFFF,
  parameter logic [11:0] WALL_RGB    = 12'h00F,
  parameter logic [11:0] WIN_RGB     = 12'h0F0,
  parameter logic [11:0] LOSE_RGB    = 12'hF00
`ifdef VGA_PLAYFIELD_BORDER_EN
  , parameter logic [11:0] BORDER_RGB = 12'h888
`endif
) (
  input  logic               clk,
  input  logic               reset,
  vga_display_ctrl_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_bright;
  logic [11:0]      r_rgb;
  logic             r_frame_tick;

  logic             w_pix_en;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_visible;
  logic [11:0]      w_rgb_nxt;

  assign w_pix_en = (r_div == DIV_LAST);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  assign w_visible = (r_h_cnt >= 10'(H_VIS_START)) && (r_h_cnt <= 10'(H_VIS_END)) &&
                     (r_v_cnt >= 10'(V_VIS_START)) && (r_v_cnt <= 10'(V_VIS_END));

`ifdef VGA_PLAYFIELD_BORDER_EN
  // Border is the outer 2-pixel ring of the playfield rectangle 264..665 x 48..501.
  logic w_in_outer;
  logic w_in_inner;
  logic w_border;

  assign w_in_outer = (r_h_cnt >= 10'd264) && (r_h_cnt <= 10'd665) &&
                      (r_v_cnt >= 10'd48)  && (r_v_cnt <= 10'd501);
  assign w_in_inner = (r_h_cnt >= 10'd266) && (r_h_cnt <= 10'd663) &&
                      (r_v_cnt >= 10'd50)  && (r_v_cnt <= 10'd499);
  assign w_border   = w_in_outer && !w_in_inner;
`endif

  always_comb begin
    w_rgb_nxt = 12'h000;
    if (w_visible) begin
      if (bus.lose)            w_rgb_nxt = LOSE_RGB;
      else if (bus.win)        w_rgb_nxt = WIN_RGB;
      else if (bus.ghostFill)  w_rgb_nxt = GHOST_RGB;
      else if (bus.pacmanFill) w_rgb_nxt = PAC_RGB;
      else if (bus.dotFill)    w_rgb_nxt = DOT_RGB;
`ifdef VGA_PLAYFIELD_BORDER_EN
      else if (w_border)       w_rgb_nxt = BORDER_RGB;
`endif
      else if (bus.wallFill)   w_rgb_nxt = WALL_RGB;
      else                     w_rgb_nxt = 12'h000;
    end
  end

  // Outputs decode the pre-increment coordinate, so they trail the counters by one pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div        <= '0;
      r_h_cnt      <= 10'd0;
      r_v_cnt      <= 10'd0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_bright     <= 1'b0;
      r_rgb        <= 12'h000;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_pix_en ? '0 : r_div + 1'b1;
      r_frame_tick <= w_pix_en && w_h_last && w_v_last;
      if (w_pix_en) begin
        r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end
        r_hsync  <= !(r_h_cnt < 10'(H_SYNC));
        r_vsync  <= !(r_v_cnt < 10'(V_SYNC));
        r_bright <= w_visible;
        r_rgb    <= w_rgb_nxt;
      end
    end
  end

  assign bus.hCount    = r_h_cnt;
  assign bus.vCount    = r_v_cnt;
  assign bus.pixEn     = w_pix_en;
  assign bus.hSync     = r_hsync;
  assign bus.vSync     = r_vsync;
  assign bus.bright    = r_bright;
  assign bus.rgb       = r_rgb;
  assign bus.frameTick = r_frame_tick;

endmodule
